// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter: round-robin front end that shares one aes_controller
// between NUM_REQ requesters. It captures the winning job, strobes the
// engine, waits for completion and returns a per-requester done pulse.
// Optional feature macro: AES_ARB_KEY_CACHE_EN enables the resident-key
// cache that drives aes_skip_key_expansion. Undefined means full key
// expansion on every job.
module aes_job_arbiter #(
    parameter  int NUM_REQ       = 2,
    parameter  int CMD_WIDTH     = 32,
    parameter  int BLK_CNT_WIDTH = 12,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]      req_cmd,
    input  logic [NUM_REQ*BLK_CNT_WIDTH-1:0]  req_blk_cnt,
    input  logic [NUM_REQ-1:0]                req_new_key,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic [NUM_REQ-1:0]                req_done,
    output logic                              aes_en,
    output logic [CMD_WIDTH-1:0]              aes_cmd,
    output logic [BLK_CNT_WIDTH-1:0]          aes_blk_cnt,
    output logic                              aes_skip_key_expansion,
    input  logic                              aes_done,
    output logic                              busy,
    output logic [ID_W-1:0]                   active_id
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t                   state;
    logic [ID_W-1:0]          rr_ptr;
    logic                     found;
    logic [ID_W-1:0]          win_id;
    logic [ID_W:0]            cand;
    logic [CMD_WIDTH-1:0]     win_cmd;
    logic [BLK_CNT_WIDTH-1:0] win_blk;
    logic                     skip_sel;

    // Round-robin search: walk offsets downward so the offset closest to
    // rr_ptr is the last match written and therefore wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (req_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                win_id = cand[ID_W-1:0];
            end
        end
    end

    assign win_cmd = req_cmd[win_id*CMD_WIDTH +: CMD_WIDTH];
    assign win_blk = req_blk_cnt[win_id*BLK_CNT_WIDTH +: BLK_CNT_WIDTH];

`ifdef AES_ARB_KEY_CACHE_EN
    logic                 kc_valid;
    logic [ID_W-1:0]      kc_id;
    logic [CMD_WIDTH-1:0] kc_cmd;

    // A requester may skip expansion only if its own schedule, built for
    // the same command, is still resident and it has not loaded a new key.
    assign skip_sel = kc_valid && (kc_id == win_id) && (kc_cmd == win_cmd) &&
                      !req_new_key[win_id];

    // Record the resident context when a job that really ran retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kc_valid <= 1'b0;
            kc_id    <= '0;
            kc_cmd   <= '0;
        end else if (state == DONE && (|req_done) && aes_blk_cnt != '0) begin
            kc_valid <= 1'b1;
            kc_id    <= active_id;
            kc_cmd   <= aes_cmd;
        end
    end
`else
    logic unused_new_key;
    assign unused_new_key = ^req_new_key;
    assign skip_sel       = 1'b0;
`endif

    // Job sequencer: grant, start strobe, wait for engine, retire.
    // DONE lasts until req_done has been high for one cycle, which gives
    // zero-count jobs their extra cycle between ack and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            rr_ptr                 <= '0;
            req_ack                <= '0;
            req_done               <= '0;
            aes_en                 <= 1'b0;
            aes_cmd                <= '0;
            aes_blk_cnt            <= '0;
            aes_skip_key_expansion <= 1'b0;
            busy                   <= 1'b0;
            active_id              <= '0;
        end else begin
            req_ack <= '0;
            aes_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        req_ack                <= ONE << win_id;
                        active_id              <= win_id;
                        aes_cmd                <= win_cmd;
                        aes_blk_cnt            <= win_blk;
                        aes_skip_key_expansion <= skip_sel;
                        busy                   <= 1'b1;
                        state                  <= (win_blk == '0) ? DONE : START;
                    end
                end
                START: begin
                    aes_en <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (aes_done) begin
                        req_done <= ONE << active_id;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (|req_done) begin
                        req_done <= '0;
                        rr_ptr   <= (active_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : active_id + 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        req_done <= ONE << active_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Directed bench for aes_job_arbiter (NUM_REQ=2). Expected skip values
// follow the AES_ARB_KEY_CACHE_EN build setting.
module tb_aes_job_arbiter;

`ifdef AES_ARB_KEY_CACHE_EN
    localparam logic C = 1'b1;
`else
    localparam logic C = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_cmd;
    logic [23:0] req_blk_cnt;
    logic [1:0]  req_new_key;
    logic [1:0]  req_ack;
    logic [1:0]  req_done;
    logic        aes_en;
    logic [31:0] aes_cmd;
    logic [11:0] aes_blk_cnt;
    logic        aes_skip_key_expansion;
    logic        aes_done;
    logic        busy;
    logic [0:0]  active_id;

    int errors = 0;
    int checks = 0;

    aes_job_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_cmd                (req_cmd),
        .req_blk_cnt            (req_blk_cnt),
        .req_new_key            (req_new_key),
        .req_ack                (req_ack),
        .req_done               (req_done),
        .aes_en                 (aes_en),
        .aes_cmd                (aes_cmd),
        .aes_blk_cnt            (aes_blk_cnt),
        .aes_skip_key_expansion (aes_skip_key_expansion),
        .aes_done               (aes_done),
        .busy                   (busy),
        .active_id              (active_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ack"},   req_ack, 0);
        chk({tag, "_done"},  req_done, 0);
        chk({tag, "_en"},    aes_en, 0);
        chk({tag, "_skip"},  aes_skip_key_expansion, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_cmd"},   aes_cmd, 0);
        chk({tag, "_blk"},   aes_blk_cnt, 0);
        chk({tag, "_id"},    active_id, 0);
    endtask

    // One job from a single requester; inputs change on the falling edge.
    task automatic job(input string tag, input int id, input logic [31:0] cmd,
                       input logic [11:0] blk, input logic nk,
                       input logic exp_skip, input int lat);
        logic [1:0] oh;
        oh = 2'b01 << id;
        req_valid = oh;
        req_cmd[id*32 +: 32]     = cmd;
        req_blk_cnt[id*12 +: 12] = blk;
        req_new_key = nk ? oh : 2'b00;
        @(negedge clk);
        chk({tag, "_ack"},  req_ack, oh);
        chk({tag, "_id"},   active_id, id);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_en0"},  aes_en, 0);
        req_valid   = 2'b00;
        req_new_key = 2'b00;
        if (blk == 0) begin
            @(negedge clk);
            chk({tag, "_zdone"}, req_done, oh);
            chk({tag, "_zen"},   aes_en, 0);
            chk({tag, "_zack"},  req_ack, 0);
            @(negedge clk);
            chk({tag, "_zidle"}, busy, 0);
            chk({tag, "_zdone0"}, req_done, 0);
        end else begin
            @(negedge clk);
            chk({tag, "_en"},   aes_en, 1);
            chk({tag, "_blk"},  aes_blk_cnt, blk);
            chk({tag, "_cmd"},  aes_cmd, cmd);
            chk({tag, "_skip"}, aes_skip_key_expansion, exp_skip);
            repeat (lat) begin
                @(negedge clk);
                chk({tag, "_en_once"}, aes_en, 0);
                chk({tag, "_cmd_hold"}, aes_cmd, cmd);
                chk({tag, "_early_done"}, req_done, 0);
            end
            aes_done = 1'b1;
            @(negedge clk);
            aes_done = 1'b0;
            chk({tag, "_done"},      req_done, oh);
            chk({tag, "_busy_done"}, busy, 1);
            @(negedge clk);
            chk({tag, "_done0"}, req_done, 0);
            chk({tag, "_idle"},  busy, 0);
        end
    endtask

    initial begin
        int exp_ord [3];
        int n;
        exp_ord = '{0, 1, 0};
        reset       = 1'b1;
        req_valid   = '0;
        req_cmd     = '0;
        req_blk_cnt = '0;
        req_new_key = '0;
        aes_done    = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 0 (cache cold).
        job("single", 0, 32'h10, 12'd4, 1'b0, 1'b0, 2);
        // Key reuse: two jobs from requester 1, same command.
        job("reuse_a", 1, 32'h20, 12'd2, 1'b0, 1'b0, 1);
        job("reuse_b", 1, 32'h20, 12'd3, 1'b0, C, 0);
        // Invalidation by new key, by new command, by an intervening requester.
        job("newkey", 1, 32'h20, 12'd1, 1'b1, 1'b0, 1);
        job("newcmd", 1, 32'h21, 12'd1, 1'b0, 1'b0, 1);
        job("other0", 0, 32'h30, 12'd1, 1'b0, 1'b0, 1);
        job("after0", 1, 32'h21, 12'd1, 1'b0, 1'b0, 1);
        // Zero-count job must not touch the cache.
        job("zero", 1, 32'h55, 12'd0, 1'b0, 1'b0, 0);
        job("postzero", 1, 32'h21, 12'd2, 1'b0, C, 1);

        // Contention: both requesters valid continuously.
        req_cmd[0 +: 32]  = 32'h30;
        req_cmd[32 +: 32] = 32'h40;
        req_blk_cnt       = {12'd1, 12'd1};
        req_valid         = 2'b11;
        for (int j = 0; j < 3; j++) begin
            n = 0;
            @(negedge clk);
            while (req_ack == 2'b00 && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk("cont_ack", req_ack, 2'b01 << exp_ord[j]);
            chk("cont_id",  active_id, exp_ord[j]);
            n = 0;
            while (!aes_en && n < 8) begin
                @(negedge clk);
                n++;
            end
            chk("cont_en", aes_en, 1);
            aes_done = 1'b1;
            @(negedge clk);
            aes_done = 1'b0;
            chk("cont_done", req_done, 2'b01 << exp_ord[j]);
            if (j == 2) req_valid = 2'b00;
        end
        @(negedge clk);
        chk("cont_idle", busy, 0);

        // Asynchronous reset while RUN, then a spurious aes_done in IDLE.
        req_cmd[0 +: 32]  = 32'h30;
        req_blk_cnt[0 +: 12] = 12'd5;
        req_valid = 2'b01;
        @(negedge clk);
        chk("rst_ack", req_ack, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_en", aes_en, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_idle_outputs("midrst");
        @(negedge clk);
        reset    = 1'b0;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        chk("spur_done", req_done, 0);
        chk("spur_busy", busy, 0);
        @(negedge clk);
        chk("spur_done2", req_done, 0);
        // Cache was cleared: same context as the last contention job gets no skip.
        job("postrst", 0, 32'h30, 12'd1, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
